// File: rtl/dsp_channel_sequencer_if.sv
// Frame-side and core-side handshake bundle for dsp_channel_sequencer.
// master = the sequencer, slave = the codec/core environment.
interface dsp_channel_sequencer_if #(
    parameter int data_width = 16,
    parameter int n_channels = 2
);
    localparam int ch_w = (n_channels > 1) ? $clog2(n_channels) : 1;

    logic [n_channels*data_width-1:0] in_frame;
    logic                             in_valid;
    logic                             ready;
    logic [n_channels*data_width-1:0] out_frame;
    logic                             out_valid;
    logic                             core_tick;
    logic [data_width-1:0]            core_sample_in;
    logic [ch_w-1:0]                  core_channel;
    logic                             core_ready;
    logic [data_width-1:0]            core_sample_out;

    modport master (
        input  in_frame, in_valid, core_ready, core_sample_out,
        output ready, out_frame, out_valid, core_tick, core_sample_in, core_channel
    );

    modport slave (
        output in_frame, in_valid, core_ready, core_sample_out,
        input  ready, out_frame, out_valid, core_tick, core_sample_in, core_channel
    );
endinterface

// File: rtl/dsp_channel_sequencer.sv
// Multi-channel frame sequencer in front of dsp_core: one core transaction per channel, atomic output frame.
// Optional macro SEQ_BYPASS_ON_ERROR_EN: in ERROR, input frames are passed through dry instead of counted as overruns.
module dsp_channel_sequencer #(
    parameter int data_width     = 16,
    parameter int n_channels     = 2,
    parameter int timeout_cycles = 4096
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           full_reset,
    input  logic                           enable,
    dsp_channel_sequencer_if.master        bus,
    output logic                           error,
    output logic [15:0]                    overrun_count,
    output logic [31:0]                    frame_count
);
    localparam int ch_w    = (n_channels > 1) ? $clog2(n_channels) : 1;
    localparam int frame_w = n_channels * data_width;
    localparam int tmo_w   = $clog2(timeout_cycles + 1);
    localparam logic [ch_w-1:0]  last_ch  = ch_w'(n_channels - 1);
    localparam logic [tmo_w-1:0] tmo_last = tmo_w'(timeout_cycles - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LAUNCH = 3'd1,
        WAIT   = 3'd2,
        DONE   = 3'd3,
        ERROR  = 3'd4
    } state_t;

    state_t              state_r;
    logic [frame_w-1:0]  frame_r;
    logic [frame_w-1:0]  stage_r;
    logic [ch_w-1:0]     chan_r;
    logic [tmo_w-1:0]    tmo_r;
    logic                skip_r;
    logic                ready_r;
    logic [frame_w-1:0]  out_frame_r;
    logic                out_valid_r;
    logic                tick_r;
    logic [data_width-1:0] sample_r;
    logic [ch_w-1:0]     core_ch_r;
    logic                error_r;
    logic [15:0]         ovr_r;
    logic [31:0]         fcnt_r;

    logic                clear_s;
    logic                overrun_s;
    logic [ch_w-1:0]     next_ch_s;
    logic [frame_w-1:0]  stage_next_s;

    assign clear_s   = !reset || full_reset;
    assign next_ch_s = chan_r + ch_w'(1);

    // Staged output frame with the current core result merged into slot k
    always_comb begin
        stage_next_s = stage_r;
        stage_next_s[int'(chan_r)*data_width +: data_width] = bus.core_sample_out;
    end

    // A frame offered while busy is dropped and counted
    always_comb begin
        overrun_s = 1'b0;
        if (bus.in_valid && (state_r != IDLE)) begin
`ifdef SEQ_BYPASS_ON_ERROR_EN
            overrun_s = (state_r != ERROR);
`else
            overrun_s = 1'b1;
`endif
        end else begin
            overrun_s = 1'b0;
        end
    end

    // Sequencer FSM; every output is a register updated on state entry
    always_ff @(posedge clk) begin
        if (clear_s) begin
            state_r     <= IDLE;
            frame_r     <= '0;
            stage_r     <= '0;
            chan_r      <= '0;
            tmo_r       <= '0;
            skip_r      <= 1'b0;
            ready_r     <= 1'b1;
            out_frame_r <= '0;
            out_valid_r <= 1'b0;
            tick_r      <= 1'b0;
            sample_r    <= '0;
            core_ch_r   <= '0;
            error_r     <= 1'b0;
            ovr_r       <= 16'd0;
            fcnt_r      <= 32'd0;
        end else begin
            tick_r      <= 1'b0;
            out_valid_r <= 1'b0;
            if (overrun_s && (ovr_r != 16'hFFFF)) begin
                ovr_r <= ovr_r + 16'd1;
            end
            case (state_r)
                IDLE: begin
                    if (bus.in_valid && enable) begin
                        frame_r   <= bus.in_frame;
                        fcnt_r    <= fcnt_r + 32'd1;
                        chan_r    <= '0;
                        ready_r   <= 1'b0;
                        tick_r    <= 1'b1;
                        sample_r  <= bus.in_frame[data_width-1:0];
                        core_ch_r <= '0;
                        state_r   <= LAUNCH;
                    end else if (bus.in_valid) begin
                        out_frame_r <= bus.in_frame;
                        out_valid_r <= 1'b1;
                    end
                end
                LAUNCH: begin
                    tmo_r   <= '0;
                    skip_r  <= 1'b1;
                    state_r <= WAIT;
                end
                WAIT: begin
                    // First WAIT cycle: the core's ready still reflects the previous job
                    if (skip_r) begin
                        skip_r <= 1'b0;
                    end else if (bus.core_ready) begin
                        stage_r <= stage_next_s;
                        if (chan_r == last_ch) begin
                            out_frame_r <= stage_next_s;
                            out_valid_r <= 1'b1;
                            state_r     <= DONE;
                        end else begin
                            chan_r    <= next_ch_s;
                            tick_r    <= 1'b1;
                            sample_r  <= frame_r[int'(next_ch_s)*data_width +: data_width];
                            core_ch_r <= next_ch_s;
                            state_r   <= LAUNCH;
                        end
                    end else if (tmo_r == tmo_last) begin
                        error_r <= 1'b1;
                        state_r <= ERROR;
                    end else begin
                        tmo_r <= tmo_r + tmo_w'(1);
                    end
                end
                DONE: begin
                    ready_r <= 1'b1;
                    state_r <= IDLE;
                end
                ERROR: begin
                    error_r <= 1'b1;
                    ready_r <= 1'b0;
`ifdef SEQ_BYPASS_ON_ERROR_EN
                    if (bus.in_valid) begin
                        out_frame_r <= bus.in_frame;
                        out_valid_r <= 1'b1;
                    end
`endif
                end
                default: begin
                    ready_r <= 1'b1;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.ready          = ready_r;
    assign bus.out_frame      = out_frame_r;
    assign bus.out_valid      = out_valid_r;
    assign bus.core_tick      = tick_r;
    assign bus.core_sample_in = sample_r;
    assign bus.core_channel   = core_ch_r;
    assign error              = error_r;
    assign overrun_count      = ovr_r;
    assign frame_count        = fcnt_r;
endmodule

// File: doc/dsp_channel_sequencer.md
Name: dsp_channel_sequencer

Overview:
Frame-level front end for the DSP core that generalises the single-sample ready/tick FSM to n_channels interleaved channels.
- Latches a multi-channel input frame and feeds one sample per channel through the core in turn.
- Collects each core result into an output frame and emits the frame atomically.
- Adds overrun counting, a core-stall timeout and a bypass path.
- Sits between the codec sample interface and dsp_core, replacing the deprecated FSM wrapper logic.

Parameters:
data_width, 16, sample width in bits
n_channels, 2, channels per frame (1..16)
timeout_cycles, 4096, maximum WAIT cycles per channel before a core-stall error

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
full_reset  in  1  synchronous active-high; same clearing effect as reset
enable  in  1  1 = process through core; 0 = bypass
in_frame  in  n_channels*data_width  input frame; channel k at bits [k*data_width +: data_width]
in_valid  in  1  one-cycle frame strobe
ready  out  1  high only in IDLE, meaning a frame can be accepted
out_frame  out  n_channels*data_width  output frame, same packing as in_frame
out_valid  out  1  one-cycle strobe; out_frame is valid in the same cycle
core_tick  out  1  one-cycle start pulse to the core
core_sample_in  out  data_width  sample presented to the core
core_channel  out  max(1,$clog2(n_channels))  channel index of the current core_sample_in
core_ready  in  1  core idle / result valid
core_sample_out  in  data_width  core result
error  out  1  sticky core-stall flag
overrun_count  out  16  saturating count of dropped frames
frame_count  out  32  accepted frames, wraps

Behaviour:
- All outputs are registered. While reset==0 or full_reset==1:
  - state=IDLE, ready=1, out_valid=0, out_frame=0, core_tick=0, core_sample_in=0, core_channel=0, error=0, counters=0.
  - Reset during any state abandons the frame; no out_valid is emitted.
- States: IDLE, LAUNCH, WAIT, DONE, ERROR.
- IDLE, in_valid && enable:
  - latch in_frame, frame_count++, channel k=0, ready<=0, go to LAUNCH.
- IDLE, in_valid && !enable (bypass):
  - out_frame<=in_frame; out_valid=1 in the next cycle; state stays IDLE; frame_count is not incremented.
- LAUNCH:
  - core_tick=1 for this cycle only; core_sample_in=latched channel k; core_channel=k.
  - Go to WAIT and clear the timeout counter.
- WAIT:
  - The first WAIT cycle always ignores core_ready (core handshake lag).
  - From the second cycle on, core_ready=1 captures core_sample_out into out_frame slot k.
  - After capture: if k==n_channels-1 go to DONE, else k++ and go to LAUNCH.
  - The timeout counter increments on each WAIT cycle without capture. When it reaches timeout_cycles: error<=1, go to ERROR.
- DONE:
  - out_valid=1 for one cycle; out_frame updates only on DONE entry. Partial results are staged internally, never visible mid-frame.
  - Next state is IDLE, with ready=1 in that cycle.
- Latency with core_ready held high: in_valid (cycle 0) to out_valid = 1+3*n_channels cycles. For n_channels=2, out_valid is in cycle 7 and ready returns in cycle 8.
- Overrun: in_valid while state!=IDLE drops the frame and increments overrun_count, saturating at 16'hFFFF. State and the in-flight frame are unaffected.
- enable falling mid-frame: the current frame completes normally; bypass applies from the next IDLE.
- ERROR:
  - Sticky until reset/full_reset; ready=0, core_tick=0.
  - in_valid counts as overrun unless SEQ_BYPASS_ON_ERROR_EN is defined.
- n_channels=1: core_channel is 1 bit wide and tied to 0.
- No arithmetic is applied to samples; they are moved verbatim.

Optional Feature:
SEQ_BYPASS_ON_ERROR_EN
- Defined: in ERROR, each in_valid copies in_frame to out_frame with out_valid one cycle later, keeping audio flowing dry; overrun_count does not increment; error stays 1.
- Undefined: ERROR is silent. No out_valid, out_frame holds its last value, and in_valid increments overrun_count.

Test Plan:
- n_channels=2, enable=1, core_ready=1 except the skip cycle; in_frame={16'h0002,16'h0001}, core echoes sample+1 → core_tick in cycles 1 and 4 with core_channel 0 then 1; out_valid in cycle 7 with out_frame={16'h0003,16'h0002}; ready=1 in cycle 8; frame_count=1.
- enable=0, in_frame=32'hABCD1234 → out_valid next cycle, out_frame=32'hABCD1234, core_tick never asserted, frame_count=0.
- Second in_valid in cycle 3 of a frame → overrun_count=1; the first frame completes with its original data; after 70000 overruns the count reads 16'hFFFF.
- timeout_cycles=8, core_ready held 0 → error=1 after 8 non-skip WAIT cycles; ready=0.
- Next in_valid in ERROR → overrun_count increments and no out_valid (macro undefined); with the macro defined, out_frame=in_frame and out_valid pulses.
- reset=0 asserted during WAIT of channel 1 → no out_valid; all outputs at reset values; a subsequent frame processes normally.
